// File: rtl/redun_mont_sq_iter.sv
// redun_mont_sq_iter: word-serial repeated Montgomery squaring with runtime modulus and redundant I/O
module redun_mont_sq_iter #(
  parameter int NUM_WRDS  = 64,
  parameter int WRD_BITS  = 16,
  parameter int ITER_BITS = 32
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_cfg_val,
  input  logic [NUM_WRDS*WRD_BITS-1:0]       i_mod,
  input  logic [WRD_BITS-1:0]                i_mod_inv,
  output logic                               o_cfg_ok,
  input  logic [NUM_WRDS*(WRD_BITS+1)-1:0]   i_sq,
  input  logic [ITER_BITS-1:0]               i_iter,
  input  logic                               i_val,
  output logic                               o_rdy,
  output logic [NUM_WRDS*(WRD_BITS+1)-1:0]   o_mul,
  output logic                               o_val,
  input  logic                               i_rdy,
  output logic                               o_busy
);
  localparam int W  = WRD_BITS;
  localparam int NW = NUM_WRDS;
  localparam int JB = $clog2(NW + 1);
  localparam int AB = $clog2(NW);
  typedef enum logic [5:0] {
    IDLE = 6'b000001,
    NORM = 6'b000010,
    MULA = 6'b000100,
    MULB = 6'b001000,
    SUB  = 6'b010000,
    DONE = 6'b100000
  } st_t;
  st_t st, st_n;
  logic [NW*W-1:0]      n_r;
  logic [W-1:0]         n_inv, m, c;
  logic [1:0]           nc;
  logic                 bw;
  logic [NW*(W+1)-1:0]  sq_r;
  logic [ITER_BITS-1:0] cnt;
  logic [W-1:0]         a [NW];
  logic [W:0]           t [NW+1];
  logic [JB-1:0]        j, i;
  logic [AB-1:0]        ji, ii;
  logic                 last, norm_last, accept;
  logic [W-1:0]         aj, nj, mx, my;
  logic [2*W-1:0]       prod, s;
  logic [W+1:0]         top, ns;
  logic [W:0]           dd;
  // shared multiplier, word adders and next-state selection
  always_comb begin
    ji        = j[AB-1:0];
    ii        = i[AB-1:0];
    last      = j == JB'(NW);
    norm_last = j == JB'(NW - 1);
    o_rdy     = (st == IDLE) && o_cfg_ok;
    o_busy    = st != IDLE;
    accept    = i_val && o_rdy && !i_cfg_val;
    aj        = a[last ? AB'(0) : ji];
    nj        = last ? '0 : n_r[ji*W +: W];
    mx        = (st == MULA) ? (last ? t[0][W-1:0] : a[ii]) : m;
    my        = (st == MULA) ? (last ? n_inv : aj) : nj;
    prod      = (2*W)'(mx) * (2*W)'(my);
    s         = (2*W)'(t[j]) + prod + (2*W)'(c);
    top       = (W+2)'(t[NW]) + (W+2)'(c);
    dd        = (W+1)'(t[j]) - (W+1)'(nj) - (W+1)'(bw);
    ns        = (W+2)'(sq_r[ji*(W+1) +: W+1]) + (W+2)'(nc);
    st_n      = (st == IDLE && accept)    ? NORM :
                (st == NORM && norm_last) ? ((cnt == '0) ? DONE : MULA) :
                (st == MULA && last)      ? MULB :
                (st == MULB && last)      ? ((i == JB'(NW - 1)) ? SUB : MULA) :
                (st == SUB && last)       ? ((cnt == ITER_BITS'(1)) ? DONE : MULA) :
                (st == DONE && o_val && i_rdy) ? IDLE : st;
  end
  // one-hot state register
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) st <= IDLE;
    else st <= st_n;
  // datapath: config, normalisation, multiply/reduce passes, final subtract, output hold
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      n_r <= '0;
      n_inv <= '0;
      o_cfg_ok <= 1'b0;
      sq_r <= '0;
      cnt <= '0;
      j <= '0;
      i <= '0;
      m <= '0;
      c <= '0;
      nc <= '0;
      bw <= 1'b0;
      o_val <= 1'b0;
      o_mul <= '0;
      for (int k = 0; k < NW; k++) a[k] <= '0;
      for (int k = 0; k <= NW; k++) t[k] <= '0;
    end else begin
      if (st == IDLE && i_cfg_val) begin
        n_r <= i_mod;
        n_inv <= i_mod_inv;
        o_cfg_ok <= 1'b1;
      end
      if (accept) begin
        sq_r <= i_sq;
        cnt <= i_iter;
        j <= '0;
        i <= '0;
        nc <= '0;
      end
      if (st == NORM) begin
        a[ji] <= ns[W-1:0];
        nc <= norm_last ? 2'b0 : ns[W+1:W];
        j <= norm_last ? '0 : j + 1'b1;
        if (norm_last) for (int k = 0; k <= NW; k++) t[k] <= '0;
      end
      if (st == MULA) begin
        if (last) begin
          t[NW] <= top[W:0];
          m <= prod[W-1:0];
          c <= '0;
        end else begin
          t[j] <= {1'b0, s[W-1:0]};
          c <= s[2*W-1:W];
        end
        j <= last ? '0 : j + 1'b1;
      end
      if (st == MULB) begin
        if (last) begin
          t[NW-1] <= {1'b0, top[W-1:0]};
          t[NW] <= (W+1)'(top[W+1:W]);
          c <= '0;
          i <= (i == JB'(NW - 1)) ? '0 : i + 1'b1;
        end else begin
          if (j != '0) t[j-1'b1] <= {1'b0, s[W-1:0]};
          c <= s[2*W-1:W];
        end
        j <= last ? '0 : j + 1'b1;
      end
      if (st == SUB) begin
        if (last) begin
          if (dd[W]) for (int k = 0; k < NW; k++) a[k] <= t[k][W-1:0];
          bw <= 1'b0;
          cnt <= cnt - 1'b1;
          for (int k = 0; k <= NW; k++) t[k] <= '0;
        end else begin
          a[ji] <= dd[W-1:0];
          bw <= dd[W];
        end
        j <= last ? '0 : j + 1'b1;
      end
      if (st == DONE) begin
        if (!o_val) begin
          o_val <= 1'b1;
          for (int k = 0; k < NW; k++) o_mul[k*(W+1) +: W+1] <= {1'b0, a[k]};
        end else if (i_rdy) o_val <= 1'b0;
      end
    end
endmodule

// File: tb/tb_redun_mont_sq_iter.sv
// tb_redun_mont_sq_iter: randomized and directed checks of the squaring engine against an arithmetic model
module tb_redun_mont_sq_iter;
  localparam int NW = 2, W = 8, IB = 32, DW = NW * (W + 1);
  localparam int S = 2 * NW * (NW + 1) + NW + 1;
  logic i_clk = 0, i_rst = 1, i_cfg_val = 0, i_val = 0, i_rdy = 1;
  logic [NW*W-1:0] i_mod = '0;
  logic [W-1:0] i_mod_inv = '0;
  logic [DW-1:0] i_sq = '0;
  logic [IB-1:0] i_iter = '0;
  logic o_cfg_ok, o_rdy, o_val, o_busy;
  logic [DW-1:0] o_mul;
  int compared = 0, mismatched = 0, pcyc = 0;
  typedef struct {longint v; int due;} exp_t;
  exp_t q[$];
  longint n_cur, rinv_cur;
  bit rand_rdy = 0, in_out = 0;

  redun_mont_sq_iter #(.NUM_WRDS(NW), .WRD_BITS(W), .ITER_BITS(IB)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cfg_val(i_cfg_val), .i_mod(i_mod), .i_mod_inv(i_mod_inv),
    .o_cfg_ok(o_cfg_ok), .i_sq(i_sq), .i_iter(i_iter), .i_val(i_val), .o_rdy(o_rdy),
    .o_mul(o_mul), .o_val(o_val), .i_rdy(i_rdy), .o_busy(o_busy));

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) pcyc <= pcyc + 1;
  always @(posedge i_clk) if (rand_rdy) begin #1 i_rdy = ($urandom_range(0, 3) != 0); end

  task automatic chk(string name, longint act, longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, pcyc);
    end
  endtask

  function automatic longint calc_rinv(longint n);
    for (longint y = 1; y < n; y++) if (((y << 16) % n) == 1) return y;
    return 0;
  endfunction

  function automatic longint calc_ninv(longint n);
    for (longint v = 0; v < 256; v++) if (((n * v + 1) % 256) == 0) return v;
    return 0;
  endfunction

  // x^(2^t) * R^(1-2^t) mod n as t plain modular squarings each scaled by R^-1
  function automatic longint mont_pow(longint x, int t, longint n, longint ri);
    longint r = x % n;
    for (int k = 0; k < t; k++) r = (r * r % n) * ri % n;
    return r;
  endfunction

  function automatic logic [DW-1:0] pack(longint v);
    logic [15:0] u = v[15:0];
    return {1'b0, u[15:8], 1'b0, u[7:0]};
  endfunction

  // split x into two 9-bit words whose weighted sum is x, optionally borrowing from the top word
  function automatic logic [DW-1:0] redund(longint x);
    longint lo = x & 255, hi = x >> 8, b;
    logic [8:0] w0, w1;
    b = (hi > 0) ? longint'($urandom_range(0, 1)) : 0;
    w0 = 9'(lo + 256 * b);
    w1 = 9'(hi - b);
    return {w1, w0};
  endfunction

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic load_cfg(longint n);
    i_mod = 16'(n);
    i_mod_inv = 8'(calc_ninv(n));
    i_cfg_val = 1;
    tick;
    i_cfg_val = 0;
    n_cur = n;
    rinv_cur = calc_rinv(n);
  endtask

  task automatic send_job(logic [DW-1:0] sq, longint x, int t);
    for (int k = 0; k < 40000 && !o_rdy; k++) tick;
    if (!o_rdy) chk("rdy_timeout", o_rdy, 1);
    i_sq = sq;
    i_iter = t;
    i_val = 1;
    tick;
    i_val = 0;
    q.push_back('{mont_pow(x, t, n_cur, rinv_cur), pcyc + NW + t * S + 1});
  endtask

  task automatic wait_idle;
    for (int k = 0; k < 40000 && q.size() > 0; k++) tick;
    if (q.size() > 0) begin
      chk("job_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  // single compare process: result value, latency and hold behaviour against the model queue
  always @(negedge i_clk) begin
    if (i_rst) in_out = 0;
    else if (o_val) begin
      if (q.size() == 0) chk("spurious_oval", o_val, 0);
      else begin
        if (!in_out) chk("oval_latency", pcyc, q[0].due);
        in_out = 1;
        chk("o_mul", o_mul, pack(q[0].v));
        chk("o_rdy_while_oval", o_rdy, 0);
        if (i_rdy) begin
          void'(q.pop_front());
          in_out = 0;
        end
      end
    end else if (q.size() > 0 && pcyc > q[0].due) begin
      chk("oval_timeout", o_val, 1);
      void'(q.pop_front());
    end
  end

  initial begin
    longint x, n;
    int t;
    repeat (3) tick;
    chk("rst_oval", o_val, 0);
    chk("rst_omul", o_mul, 0);
    chk("rst_cfg_ok", o_cfg_ok, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_rdy", o_rdy, 0);
    i_rst = 0;
    tick;
    chk("pin_ninv", calc_ninv(65521), 'hEF);
    chk("pin_rinv", calc_rinv(65521), 'hEEE1);
    chk("pin_mont_one", mont_pow(15, 1000, 65521, 'hEEE1), 15);
    chk("pin_nm1", mont_pow('hFFF0, 1, 65521, 'hEEE1), 'hEEE1);
    chk("pin_zero", mont_pow(0, 5, 65521, 'hEEE1), 0);
    chk("pin_t0", mont_pow('h2FF, 0, 65521, 'hEEE1), 'h2FF);
    i_val = 1;
    repeat (5) begin
      tick;
      chk("nocfg_busy", o_busy, 0);
      chk("nocfg_rdy", o_rdy, 0);
    end
    i_mod = 16'hFFF1;
    i_mod_inv = 8'hEF;
    i_cfg_val = 1;
    tick;
    i_cfg_val = 0;
    i_val = 0;
    n_cur = 65521;
    rinv_cur = calc_rinv(65521);
    chk("cfg_ok_set", o_cfg_ok, 1);
    chk("cfg_val_ignored", o_busy, 0);
    send_job({9'h001, 9'h1FF}, 'h2FF, 0);
    for (int k = 0; k < 50 && !o_val; k++) tick;
    chk("t1_literal", o_mul, 18'h004FF);
    wait_idle;
    send_job(redund(15), 15, 1000);
    wait_idle;
    send_job(redund('hFFF0), 'hFFF0, 1);
    for (int k = 0; k < 100 && !o_val; k++) tick;
    chk("t3_literal", o_mul, pack('hEEE1));
    wait_idle;
    send_job(redund(0), 0, 5);
    wait_idle;
    i_rdy = 0;
    x = $urandom_range(0, 65520);
    send_job(redund(x), x, 2);
    for (int k = 0; k < 200 && !o_val; k++) tick;
    repeat (20) begin
      tick;
      chk("hold_oval", o_val, 1);
      chk("hold_omul", o_mul, pack(mont_pow(x, 2, 65521, rinv_cur)));
      chk("hold_rdy", o_rdy, 0);
    end
    i_rdy = 1;
    tick;
    chk("xfer_oval_low", o_val, 0);
    chk("rdy_after_xfer", o_rdy, 1);
    wait_idle;
    x = $urandom_range(0, 65520);
    send_job(redund(x), x, 2);
    repeat (5) tick;
    i_mod = 16'h8001;
    i_mod_inv = 8'(calc_ninv('h8001));
    i_cfg_val = 1;
    tick;
    i_cfg_val = 0;
    wait_idle;
    x = $urandom_range(0, 65520);
    send_job(redund(x), x, 3);
    wait_idle;
    for (int cfg = 0; cfg < 3; cfg++) begin
      n = longint'($urandom_range(3, 65535)) | 1;
      load_cfg(n);
      rand_rdy = 1;
      for (int jb = 0; jb < 8; jb++) begin
        x = $urandom_range(0, 32'(n - 1));
        t = $urandom_range(0, 6);
        send_job(redund(x), x, t);
      end
      wait_idle;
      rand_rdy = 0;
      tick;
      i_rdy = 1;
      tick;
    end
    load_cfg(65521);
    x = $urandom_range(1, 65520);
    send_job(redund(x), x, 3);
    repeat (6) tick;
    chk("busy_before_rst", o_busy, 1);
    i_rst = 1;
    #1;
    q.delete();
    chk("arst_oval", o_val, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_cfg_ok", o_cfg_ok, 0);
    tick;
    i_rst = 0;
    repeat (40) tick;
    chk("post_rst_cfg_ok", o_cfg_ok, 0);
    chk("post_rst_rdy", o_rdy, 0);
    load_cfg(65521);
    x = $urandom_range(0, 65520);
    send_job(redund(x), x, 2);
    wait_idle;
    repeat (3) tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
